digit_serial_addsub: RTL and testbench

DIGIT_SERIAL_ADDSUB -- requirements
Module: digit_serial_addsub

---
 rtl/digit_serial_addsub.sv | 87 ++++++++
 tb/tb_digit_serial_addsub.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub: digit-serial two's-complement adder/subtractor, least-significant digit first
module digit_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic             in_valid,
    input  logic [DIGIT-1:0] a_in,
    input  logic [DIGIT-1:0] b_in,
    output logic [DIGIT-1:0] sum_out,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW = $clog2(NDIG + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic             sub_r, carry, acc, last;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] bx;
    logic [DIGIT:0]   t;

    generate
        if (DIGIT < 1 || DIGIT > WIDTH || WIDTH % DIGIT != 0) begin : g_bad_params
            $fatal(1, "digit_serial_addsub: DIGIT must divide WIDTH and not exceed it");
        end
    endgenerate

    assign busy = state != IDLE;
    assign done = state == DONE;

    // digit adder, beat acceptance and next-state selection
    always_comb begin
        bx = b_in ^ {DIGIT{sub_r}};
        t = {1'b0, a_in} + {1'b0, bx} + {{DIGIT{1'b0}}, carry};
        acc = state == RUN && in_valid;
        last = cnt == CW'(NDIG - 1);
        state_nx = state == IDLE ? (start ? RUN : IDLE) :
                   state == RUN  ? (acc && last ? DONE : RUN) : IDLE;
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // datapath: latch mode on start, then fold one digit per accepted beat into the result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sub_r     <= 1'b0;
            carry     <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            sum_out   <= '0;
            out_valid <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= acc;
            if (state == IDLE && start) begin
                sub_r  <= sub;
                carry  <= sub;
                cnt    <= '0;
                result <= '0;
            end else if (acc) begin
                sum_out <= t[DIGIT-1:0];
                carry   <= t[DIGIT];
                cnt     <= cnt + 1'b1;
                result  <= result | (WIDTH'(t[DIGIT-1:0]) << (cnt * DIGIT));
                if (last) begin
                    carry_out <= t[DIGIT];
                    overflow  <= (a_in[DIGIT-1] == bx[DIGIT-1]) && (t[DIGIT-1] != a_in[DIGIT-1]);
                end
            end
        end
    end
endmodule

// File: tb/tb_digit_serial_addsub.sv
// tb_digit_serial_addsub: directed checks of four digit_serial_addsub configurations
module tb_digit_serial_addsub;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    logic       st1 = 0, sb1 = 0, iv1 = 0;
    logic [0:0] a1 = '0, b1 = '0, so1;
    logic       ov1, by1, dn1, co1, of1;
    logic [7:0] r1;

    logic       st2 = 0, sb2 = 0, iv2 = 0;
    logic [1:0] a2 = '0, b2 = '0, so2;
    logic       ov2, by2, dn2, co2, of2;
    logic [7:0] r2;

    logic       st4 = 0, sb4 = 0, iv4 = 0;
    logic [3:0] a4 = '0, b4 = '0, so4;
    logic       ov4, by4, dn4, co4, of4;
    logic [7:0] r4;

    logic        stg = 0, sbg = 0, ivg = 0;
    logic [15:0] ag = '0, bg = '0, sog;
    logic        ovg, byg, dng, cog, ofg;
    logic [15:0] rg;

    digit_serial_addsub #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .reset(reset), .start(st1), .sub(sb1), .in_valid(iv1), .a_in(a1), .b_in(b1),
        .sum_out(so1), .out_valid(ov1), .busy(by1), .done(dn1), .result(r1), .carry_out(co1), .overflow(of1));
    digit_serial_addsub #(.WIDTH(8), .DIGIT(2)) u_d2 (
        .clk(clk), .reset(reset), .start(st2), .sub(sb2), .in_valid(iv2), .a_in(a2), .b_in(b2),
        .sum_out(so2), .out_valid(ov2), .busy(by2), .done(dn2), .result(r2), .carry_out(co2), .overflow(of2));
    digit_serial_addsub #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .reset(reset), .start(st4), .sub(sb4), .in_valid(iv4), .a_in(a4), .b_in(b4),
        .sum_out(so4), .out_valid(ov4), .busy(by4), .done(dn4), .result(r4), .carry_out(co4), .overflow(of4));
    digit_serial_addsub #(.WIDTH(16), .DIGIT(16)) u_dg (
        .clk(clk), .reset(reset), .start(stg), .sub(sbg), .in_valid(ivg), .a_in(ag), .b_in(bg),
        .sum_out(sog), .out_valid(ovg), .busy(byg), .done(dng), .result(rg), .carry_out(cog), .overflow(ofg));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({so1, ov1, by1, dn1, r1, co1, of1} !== '0) begin
            errors++; $display("FAIL reset_d1 got=%h exp=0", {so1, ov1, by1, dn1, r1, co1, of1});
        end
        checks++;
        if ({so2, ov2, by2, dn2, r2, co2, of2} !== '0) begin
            errors++; $display("FAIL reset_d2 got=%h exp=0", {so2, ov2, by2, dn2, r2, co2, of2});
        end
        checks++;
        if ({so4, ov4, by4, dn4, r4, co4, of4} !== '0) begin
            errors++; $display("FAIL reset_d4 got=%h exp=0", {so4, ov4, by4, dn4, r4, co4, of4});
        end
        checks++;
        if ({sog, ovg, byg, dng, rg, cog, ofg} !== '0) begin
            errors++; $display("FAIL reset_d16 got=%h exp=0", {sog, ovg, byg, dng, rg, cog, ofg});
        end
        step();
        reset = 1'b0;
    endtask

    task automatic test_add_d1;
        logic [7:0] a = 8'h5A, b = 8'h3C, e = 8'h96;
        int dc = -1;
        st1 = 1; sb1 = 0;
        for (int c = 1; c <= 12; c++) begin
            step();
            st1 = 0;
            if (dn1 === 1'b1 && dc < 0) dc = c;
            if (c >= 2 && c <= 9) begin
                checks++;
                if (ov1 !== 1'b1 || so1 !== e[c-2]) begin
                    errors++; $display("FAIL add_d1_digit%0d got=%b/%b exp=1/%b", c - 2, ov1, so1, e[c-2]);
                end
            end
            if (c == 10) begin
                checks++;
                if ({by1, dn1, ov1} !== 3'b000) begin
                    errors++; $display("FAIL add_d1_after_done got=%b exp=000", {by1, dn1, ov1});
                end
            end
            iv1 = c <= 8;
            if (c <= 8) begin a1 = a[c-1]; b1 = b[c-1]; end
        end
        checks++;
        if (dc !== 9) begin errors++; $display("FAIL add_d1_latency got=%0d exp=9", dc); end
        checks++;
        if ({r1, co1, of1} !== {8'h96, 1'b0, 1'b1}) begin
            errors++; $display("FAIL add_d1_result got=%h/%b/%b exp=96/0/1", r1, co1, of1);
        end
    endtask

    task automatic test_sub_d4;
        logic [7:0] a = 8'h10, b = 8'h20;
        int dc = -1;
        st4 = 1; sb4 = 1;
        for (int c = 1; c <= 5; c++) begin
            step();
            st4 = 0;
            if (dn4 === 1'b1 && dc < 0) dc = c;
            if (c == 1) begin
                checks++;
                if (by4 !== 1'b1) begin errors++; $display("FAIL sub_d4_busy got=%b exp=1", by4); end
            end
            if (c == 3) begin
                checks++;
                if ({dn4, ov4, so4} !== {1'b1, 1'b1, 4'hF}) begin
                    errors++; $display("FAIL sub_d4_last_digit got=%b/%b/%h exp=1/1/f", dn4, ov4, so4);
                end
            end
            iv4 = c <= 2;
            if (c <= 2) begin a4 = a[(c-1)*4 +: 4]; b4 = b[(c-1)*4 +: 4]; end
        end
        checks++;
        if (dc !== 3) begin errors++; $display("FAIL sub_d4_latency got=%0d exp=3", dc); end
        checks++;
        if ({r4, co4, of4} !== {8'hF0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL sub_d4_result got=%h/%b/%b exp=f0/0/0", r4, co4, of4);
        end
    endtask

    task automatic test_stall_d2;
        logic [7:0] a = 8'hFF, b = 8'h01;
        int dc = -1;
        int k;
        st2 = 1; sb2 = 0;
        for (int c = 1; c <= 11; c++) begin
            step();
            st2 = 0;
            if (dn2 === 1'b1 && dc < 0) dc = c;
            if (c == 3) begin
                checks++;
                if ({ov2, so2} !== {1'b1, 2'b00}) begin
                    errors++; $display("FAIL stall_d2_digit1 got=%b/%b exp=1/00", ov2, so2);
                end
            end
            if (c >= 4 && c <= 6) begin
                checks++;
                if (ov2 !== 1'b0) begin errors++; $display("FAIL stall_d2_gap%0d got=%b exp=0", c, ov2); end
            end
            iv2 = c <= 2 || (c >= 6 && c <= 7);
            k = c <= 2 ? c - 1 : c - 4;
            if (iv2) begin a2 = a[k*2 +: 2]; b2 = b[k*2 +: 2]; end
            else begin a2 = 2'b11; b2 = 2'b11; end
        end
        checks++;
        if (dc !== 8) begin errors++; $display("FAIL stall_d2_latency got=%0d exp=8", dc); end
        checks++;
        if ({r2, co2, of2} !== {8'h00, 1'b1, 1'b0}) begin
            errors++; $display("FAIL stall_d2_result got=%h/%b/%b exp=00/1/0", r2, co2, of2);
        end
    endtask

    task automatic test_start_held;
        logic [7:0] x = 8'h12, y = 8'h34, p = 8'h0F, q = 8'h01;
        st4 = 1; sb4 = 0;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 3) begin
                checks++;
                if ({dn4, by4, r4} !== {1'b1, 1'b1, 8'h46}) begin
                    errors++; $display("FAIL held_first_done got=%b/%b/%h exp=1/1/46", dn4, by4, r4);
                end
            end
            if (c == 4) begin
                checks++;
                if ({dn4, by4, r4} !== {1'b0, 1'b0, 8'h46}) begin
                    errors++; $display("FAIL held_idle_gap got=%b/%b/%h exp=0/0/46", dn4, by4, r4);
                end
            end
            if (c == 5) begin
                checks++;
                if ({dn4, by4} !== 2'b01) begin
                    errors++; $display("FAIL held_restart got=%b/%b exp=0/1", dn4, by4);
                end
            end
            if (c == 7) begin
                checks++;
                if ({dn4, r4, co4, of4} !== {1'b1, 8'h10, 1'b0, 1'b0}) begin
                    errors++; $display("FAIL held_second_done got=%b/%h/%b/%b exp=1/10/0/0", dn4, r4, co4, of4);
                end
            end
            if (c == 8) begin
                checks++;
                if ({dn4, by4} !== 2'b00) begin
                    errors++; $display("FAIL held_second_idle got=%b/%b exp=0/0", dn4, by4);
                end
            end
            iv4 = c <= 6;
            if (c <= 2) begin a4 = x[(c-1)*4 +: 4]; b4 = y[(c-1)*4 +: 4]; end
            else if (c <= 4) begin a4 = 4'hF; b4 = 4'hF; end
            else if (c <= 6) begin a4 = p[(c-5)*4 +: 4]; b4 = q[(c-5)*4 +: 4]; end
        end
        st4 = 0;
        iv4 = 0;
        step();
    endtask

    task automatic test_reset_mid;
        int dc = -1;
        st1 = 1; sb1 = 0;
        for (int c = 1; c <= 2; c++) begin
            step();
            st1 = 0;
            iv1 = 1; a1 = 1'b1; b1 = 1'b1;
        end
        step();
        iv1 = 0;
        checks++;
        if ({by1, r1, so1} !== {1'b1, 8'h02, 1'b1}) begin
            errors++; $display("FAIL midreset_before got=%b/%h/%b exp=1/02/1", by1, r1, so1);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({so1, ov1, by1, dn1, r1, co1, of1} !== '0) begin
            errors++; $display("FAIL midreset_async_clear got=%h exp=0", {so1, ov1, by1, dn1, r1, co1, of1});
        end
        step();
        reset = 1'b0;
        st1 = 1; sb1 = 0;
        for (int c = 1; c <= 11; c++) begin
            step();
            st1 = 0;
            if (dn1 === 1'b1 && dc < 0) dc = c;
            iv1 = c <= 8;
            a1 = c == 1; b1 = c == 1;
        end
        checks++;
        if (dc !== 9) begin errors++; $display("FAIL midreset_latency got=%0d exp=9", dc); end
        checks++;
        if ({r1, co1, of1} !== {8'h02, 1'b0, 1'b0}) begin
            errors++; $display("FAIL midreset_result got=%h/%b/%b exp=02/0/0", r1, co1, of1);
        end
    endtask

    task automatic test_full_width;
        int dc = -1;
        stg = 1; sbg = 1;
        for (int c = 1; c <= 4; c++) begin
            step();
            stg = 0;
            if (dng === 1'b1 && dc < 0) begin
                dc = c;
                checks++;
                if ({ovg, sog} !== {1'b1, 16'h7FFF}) begin
                    errors++; $display("FAIL full_digit got=%b/%h exp=1/7fff", ovg, sog);
                end
            end
            ivg = c == 1;
            ag = 16'h8000; bg = 16'h0001;
        end
        checks++;
        if (dc !== 2) begin errors++; $display("FAIL full_latency got=%0d exp=2", dc); end
        checks++;
        if ({rg, cog, ofg} !== {16'h7FFF, 1'b1, 1'b1}) begin
            errors++; $display("FAIL full_result got=%h/%b/%b exp=7fff/1/1", rg, cog, ofg);
        end
    endtask

    initial begin
        test_reset();
        test_add_d1();
        test_sub_d4();
        test_stall_d2();
        test_start_held();
        test_reset_mid();
        test_full_width();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
